// File: rtl/lsq_buffer.sv
// lsq_buffer: parametrised in-order load/store queue between dispatcher and LSU.
// Ops are held in a circular buffer, operands are resolved from the ALU/LSU
// broadcast buses, and one op per cycle leaves from the head: loads once their
// operands are ready, stores only after RoB commit. Rollback keeps the
// committed-but-unissued stores at the head.
// Optional feature: define LSQ_PERF_EN to add the perf_* counter outputs.
// Op classification and the IO port address normally come from defines.v; the
// fallbacks below are used only when that file has not been included.

`ifndef LHU
`define LHU 6'd4
`endif
`ifndef SB
`define SB 6'd5
`endif
`ifndef RAM_IO_PORT
`define RAM_IO_PORT 32'h0003_0000
`endif

module lsq_buffer #(
   parameter int DEPTH = 16,
   parameter int ROB_W = 5
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             disp_en,
   input  logic [5:0]       disp_op,
   input  logic [ROB_W-1:0] disp_q1,
   input  logic [ROB_W-1:0] disp_q2,
   input  logic [31:0]      disp_v1,
   input  logic [31:0]      disp_v2,
   input  logic [31:0]      disp_imm,
   input  logic [ROB_W-1:0] disp_rob_id,
   output logic             full_out,
   output logic             empty_out,
   input  logic             alu_valid,
   input  logic [31:0]      alu_result,
   input  logic [ROB_W-1:0] alu_rob_id,
   input  logic             lsu_valid,
   input  logic [31:0]      lsu_result,
   input  logic [ROB_W-1:0] lsu_rob_id,
   input  logic             lsu_busy,
   output logic             lsu_req_en,
   output logic [5:0]       lsu_req_op,
   output logic [31:0]      lsu_req_addr,
   output logic [31:0]      lsu_req_data,
   output logic [ROB_W-1:0] lsu_req_rob_id,
   input  logic             commit_en,
   input  logic [ROB_W-1:0] commit_rob_id,
   input  logic [ROB_W-1:0] head_io_rob_id,
   output logic [ROB_W-1:0] io_rob_id_out,
   input  logic             rollback
`ifdef LSQ_PERF_EN
   ,
   output logic [31:0]      perf_loads,
   output logic [31:0]      perf_stores,
   output logic [31:0]      perf_stall,
   output logic [31:0]      perf_flush
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   function automatic logic is_load(input logic [5:0] op);
      return (op <= `LHU);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op >= `SB);
   endfunction

   // Resolve one operand against both broadcast buses; ALU wins a tie.
   function automatic logic [ROB_W+31:0] resolve(
      input logic [ROB_W-1:0] q,
      input logic [31:0]      v,
      input logic             av,
      input logic [31:0]      ar,
      input logic [ROB_W-1:0] aid,
      input logic             lv,
      input logic [31:0]      lr,
      input logic [ROB_W-1:0] lid
   );
      if (q != '0 && av && aid == q)
         return {{ROB_W{1'b0}}, ar};
      else if (q != '0 && lv && lid == q)
         return {{ROB_W{1'b0}}, lr};
      else
         return {q, v};
   endfunction

   // entry storage
   logic             r_valid [DEPTH];
   logic             r_cmt   [DEPTH];
   logic [5:0]       r_op    [DEPTH];
   logic [ROB_W-1:0] r_q1    [DEPTH];
   logic [ROB_W-1:0] r_q2    [DEPTH];
   logic [31:0]      r_v1    [DEPTH];
   logic [31:0]      r_v2    [DEPTH];
   logic [31:0]      r_imm   [DEPTH];
   logic [ROB_W-1:0] r_rob   [DEPTH];

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic             r_req_vld_p1;
   logic [5:0]       r_req_op_p1;
   logic [31:0]      r_req_addr_p1;
   logic [31:0]      r_req_data_p1;
   logic [ROB_W-1:0] r_req_rob_p1;

   logic             w_h_valid;
   logic [5:0]       w_h_op;
   logic [31:0]      w_h_addr;
   logic [ROB_W-1:0] w_h_rob;
   logic             w_h_ready;
   logic             w_h_load;
   logic             w_h_store;
   logic             w_h_io;
   logic             w_issue;
   logic             w_full;
   logic             w_insert;
   logic [ROB_W+31:0] w_ins1;
   logic [ROB_W+31:0] w_ins2;
   logic [DEPTH-1:0] w_keep;
   logic [CNT_W-1:0] w_keep_cnt;
   logic             w_run;
   logic [PTR_W-1:0] w_idx;

   // Head decode and the single-issue / insert decisions.
   always_comb begin
      w_h_valid = r_valid[r_head];
      w_h_op    = r_op[r_head];
      w_h_addr  = r_v1[r_head] + r_imm[r_head];
      w_h_rob   = r_rob[r_head];
      w_h_ready = (r_q1[r_head] == '0) && (r_q2[r_head] == '0);
      w_h_load  = is_load(w_h_op);
      w_h_store = is_store(w_h_op);
      w_h_io    = (w_h_addr == `RAM_IO_PORT);
      w_issue   = w_h_valid && w_h_ready && !lsu_busy &&
                  ((w_h_load && (!w_h_io || head_io_rob_id == w_h_rob)) ||
                   (w_h_store && r_cmt[r_head]));
      w_full    = (r_count == CNT_W'(DEPTH));
      // A full queue still accepts an insert when the head leaves in the same cycle.
      w_insert  = disp_en && (!w_full || w_issue);
      w_ins1    = resolve(disp_q1, disp_v1, alu_valid, alu_result, alu_rob_id,
                          lsu_valid, lsu_result, lsu_rob_id);
      w_ins2    = resolve(disp_q2, disp_v2, alu_valid, alu_result, alu_rob_id,
                          lsu_valid, lsu_result, lsu_rob_id);
   end

   // Rollback survivors: the run of committed stores starting at the head.
   always_comb begin
      w_keep     = '0;
      w_keep_cnt = '0;
      w_run      = 1'b1;
      w_idx      = r_head;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_head + PTR_W'(i);
         if (w_run && r_valid[w_idx] && is_store(r_op[w_idx]) && r_cmt[w_idx]) begin
            w_keep[w_idx] = 1'b1;
            w_keep_cnt    = w_keep_cnt + CNT_W'(1);
         end else begin
            w_run = 1'b0;
         end
      end
   end

   // Entry payload: wake-up from broadcasts, then the dispatcher write at tail.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !rollback) begin
         for (int i = 0; i < DEPTH; i++) begin
            {r_q1[i], r_v1[i]} <= resolve(r_q1[i], r_v1[i], alu_valid, alu_result,
                                          alu_rob_id, lsu_valid, lsu_result, lsu_rob_id);
            {r_q2[i], r_v2[i]} <= resolve(r_q2[i], r_v2[i], alu_valid, alu_result,
                                          alu_rob_id, lsu_valid, lsu_result, lsu_rob_id);
         end
         if (w_insert) begin
            r_op[r_tail]               <= disp_op;
            r_imm[r_tail]              <= disp_imm;
            r_rob[r_tail]              <= disp_rob_id;
            {r_q1[r_tail], r_v1[r_tail]} <= w_ins1;
            {r_q2[r_tail], r_v2[r_tail]} <= w_ins2;
         end
      end
   end

   // Control state: valid/committed flags, pointers, count and the LSU request.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_cmt[i]   <= 1'b0;
         end
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_req_vld_p1  <= 1'b0;
         r_req_op_p1   <= '0;
         r_req_addr_p1 <= '0;
         r_req_data_p1 <= '0;
         r_req_rob_p1  <= '0;
      end else if (rdy_in) begin
         if (rollback) begin
            for (int i = 0; i < DEPTH; i++)
               r_valid[i] <= w_keep[i];
            r_tail       <= r_head + w_keep_cnt[PTR_W-1:0];
            r_count      <= w_keep_cnt;
            r_req_vld_p1 <= 1'b0;
         end else begin
            if (commit_en) begin
               for (int i = 0; i < DEPTH; i++)
                  if (r_valid[i] && r_rob[i] == commit_rob_id)
                     r_cmt[i] <= 1'b1;
            end
            // ---- stage p1: registered LSU request ----
            r_req_vld_p1 <= w_issue;
            if (w_issue) begin
               r_req_op_p1     <= w_h_op;
               r_req_addr_p1   <= w_h_addr;
               r_req_data_p1   <= r_v2[r_head];
               r_req_rob_p1    <= w_h_rob;
               r_valid[r_head] <= 1'b0;
               r_cmt[r_head]   <= 1'b0;
               r_head          <= r_head + PTR_W'(1);
            end
            // Written after the issue clear so a full-queue insert reuses the freed slot.
            if (w_insert) begin
               r_valid[r_tail] <= 1'b1;
               r_cmt[r_tail]   <= 1'b0;
               r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_insert && !w_issue)
               r_count <= r_count + CNT_W'(1);
            else if (!w_insert && w_issue)
               r_count <= r_count - CNT_W'(1);
         end
      end
   end

   assign full_out       = w_full;
   assign empty_out      = (r_count == '0);
   assign io_rob_id_out  = (w_h_valid && w_h_load && r_q1[r_head] == '0 && w_h_io) ?
                           w_h_rob : '0;
   assign lsu_req_en     = r_req_vld_p1;
   assign lsu_req_op     = r_req_op_p1;
   assign lsu_req_addr   = r_req_addr_p1;
   assign lsu_req_data   = r_req_data_p1;
   assign lsu_req_rob_id = r_req_rob_p1;

`ifdef LSQ_PERF_EN
   logic [31:0] r_perf_loads;
   logic [31:0] r_perf_stores;
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flush;

   // Wrapping activity counters: issued loads/stores, stalled head cycles, flushes.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_perf_loads  <= '0;
         r_perf_stores <= '0;
         r_perf_stall  <= '0;
         r_perf_flush  <= '0;
      end else if (rdy_in) begin
         if (rollback) begin
            r_perf_flush <= r_perf_flush + 32'd1;
         end else begin
            if (w_issue && w_h_load)
               r_perf_loads <= r_perf_loads + 32'd1;
            if (w_issue && w_h_store)
               r_perf_stores <= r_perf_stores + 32'd1;
            if (w_h_valid && !w_issue)
               r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign perf_loads  = r_perf_loads;
   assign perf_stores = r_perf_stores;
   assign perf_stall  = r_perf_stall;
   assign perf_flush  = r_perf_flush;
`endif

endmodule
